// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared-memory port around mem_arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ready;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the mips32 fetch and load/store ports.
// LS wins contention until IF has been passed over STARVE_LIMIT times in a row.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              store_q, store_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic can_accept;
    logic grant_if;
    logic grant_ls;
    logic if_accept;
    logic ls_accept;

    // Ready is held low while rst is high so every output reads 0 during reset.
    always_comb begin
        can_accept = !rst && (state_q == IDLE || state_q == RESP);
        grant_ls   = bus.ls_req && (!bus.if_req || starve_q != STARVE_MAX);
        grant_if   = bus.if_req && !grant_ls;
        if_accept  = can_accept && grant_if;
        ls_accept  = can_accept && grant_ls;
    end

    assign bus.if_ready  = if_accept;
    assign bus.ls_ready  = ls_accept;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        starve_d    = starve_q;
        store_d     = store_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (if_accept || ls_accept) begin
                    state_d    = ISSUE;
                    owner_d    = ls_accept ? OWN_LS : OWN_IF;
                    store_d    = ls_accept && bus.ls_we;
                    mem_en_d   = 1'b1;
                    mem_we_d   = ls_accept && bus.ls_we;
                    mem_addr_d = ls_accept ? bus.ls_addr : bus.if_addr;
                    if (ls_accept) begin
                        mem_wdata_d = bus.ls_wdata;
                    end
                end else begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = WAIT;
            end
            WAIT: begin
                // Counter reaching zero marks the cycle mem_rdata is valid.
                if (lat_cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = store_q ? '0 : bus.mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.if_req || if_accept) begin
            starve_d = '0;
        end else if (ls_accept && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            lat_cnt_q   <= '0;
            starve_q    <= '0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            starve_q    <= starve_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end
endmodule
